// File: rtl/turbo_iter_sched_if.sv
// Handshake bundle between the turbo iteration scheduler and its surroundings:
// frame control and unit completions in, unit launches and frame status out.
interface turbo_iter_sched_if #(
  parameter int MAX_ITER = 8
) ();
  localparam int IW = $clog2(MAX_ITER + 1);

  logic          start;
  logic          abort;
  logic          early_stop;
  logic          alpha_out_valid;
  logic          beta_out_valid;
  logic          ext_out_valid;
  logic          alpha_in_valid;
  logic          beta_in_valid;
  logic          ext_in_valid;
  logic          dec_sel;
  logic [IW-1:0] iter;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  // Control/datapath side.
  modport master (
    output start, abort, early_stop, alpha_out_valid, beta_out_valid, ext_out_valid,
    input  alpha_in_valid, beta_in_valid, ext_in_valid, dec_sel, iter, busy,
           frame_done, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  start, abort, early_stop, alpha_out_valid, beta_out_valid, ext_out_valid,
    output alpha_in_valid, beta_in_valid, ext_in_valid, dec_sel, iter, busy,
           frame_done, timeout_err
  );
endinterface

// File: rtl/turbo_iter_sched.sv
// Turbo decoder iteration scheduler: alternates alpha/beta then extrinsic passes
// for decoder 1 and decoder 2, with iteration count, early stop, abort and watchdog.
module turbo_iter_sched #(
  parameter int MAX_ITER = 8,
  parameter int TIMEOUT  = 1024,
  parameter int IW       = $clog2(MAX_ITER + 1)
) (
  input logic               clk,
  input logic               reset,
  turbo_iter_sched_if.slave sif
);
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LAUNCH_AB, WAIT_AB, LAUNCH_EXT, WAIT_EXT, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic             dec_sel_q, dec_sel_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             terr_q, terr_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             alpha_iv_q, beta_iv_q, ext_iv_q, busy_q, done_q;

  logic             wd_expired;
  logic [IW-1:0]    iter_inc;

  // The current wait cycle is the TIMEOUT-th one when the counter shows TIMEOUT-1.
  assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
  assign iter_inc   = iter_q + IW'(1);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dec_sel_d = dec_sel_q;
    iter_d    = iter_q;
    terr_d    = terr_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    wd_d      = wd_q;

    case (state_q)
      IDLE: begin
        if (sif.start) begin
          iter_d    = '0;
          dec_sel_d = 1'b0;
          terr_d    = 1'b0;
          state_d   = LAUNCH_AB;
        end
      end
      LAUNCH_AB: begin
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        wd_d     = '0;
        state_d  = sif.abort ? FINISH : WAIT_AB;
      end
      WAIT_AB: begin
        a_done_d = a_done_q | sif.alpha_out_valid;
        b_done_d = b_done_q | sif.beta_out_valid;
        wd_d     = wd_q + WDW'(1);
        if (sif.abort) begin
          state_d = FINISH;
        end else if (a_done_d && b_done_d) begin
          state_d = LAUNCH_EXT;
        end else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = FINISH;
        end
      end
      LAUNCH_EXT: begin
        wd_d    = '0;
        state_d = sif.abort ? FINISH : WAIT_EXT;
      end
      WAIT_EXT: begin
        wd_d = wd_q + WDW'(1);
        if (sif.abort) begin
          state_d = FINISH;
        end else if (sif.ext_out_valid) begin
          if (!dec_sel_q) begin
            dec_sel_d = 1'b1;
            state_d   = LAUNCH_AB;
          end else begin
            // Decoder 2 closes a full iteration; early_stop only matters here.
            iter_d = iter_inc;
            if (sif.early_stop || iter_inc == IW'(MAX_ITER)) begin
              state_d = FINISH;
            end else begin
              dec_sel_d = 1'b0;
              state_d   = LAUNCH_AB;
            end
          end
        end else if (wd_expired) begin
          terr_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dec_sel_q  <= 1'b0;
      iter_q     <= '0;
      terr_q     <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      wd_q       <= '0;
      alpha_iv_q <= 1'b0;
      beta_iv_q  <= 1'b0;
      ext_iv_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_sel_q  <= dec_sel_d;
      iter_q     <= iter_d;
      terr_q     <= terr_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      wd_q       <= wd_d;
      // Outputs are decoded from the next state so they come straight off flops.
      alpha_iv_q <= (state_d == LAUNCH_AB);
      beta_iv_q  <= (state_d == LAUNCH_AB);
      ext_iv_q   <= (state_d == LAUNCH_EXT);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FINISH);
    end
  end

  assign sif.alpha_in_valid = alpha_iv_q;
  assign sif.beta_in_valid  = beta_iv_q;
  assign sif.ext_in_valid   = ext_iv_q;
  assign sif.dec_sel        = dec_sel_q;
  assign sif.iter           = iter_q;
  assign sif.busy           = busy_q;
  assign sif.frame_done     = done_q;
  assign sif.timeout_err    = terr_q;
endmodule

// File: tb/tb_turbo_iter_sched.sv
// Scoreboard bench for turbo_iter_sched: a frame model predicts every launch and
// frame_done pulse (cycle, dec_sel, iter, timeout_err) and a monitor checks them.
module tb_turbo_iter_sched;
  localparam int MAX_ITER = 2;
  localparam int TIMEOUT  = 100;
  localparam int IW       = $clog2(MAX_ITER + 1);

  localparam logic [3:0] EV_AB   = 4'b1100;  // {alpha, beta, ext, frame_done}
  localparam logic [3:0] EV_EXT  = 4'b0010;
  localparam logic [3:0] EV_DONE = 4'b0001;

  typedef struct {
    logic [3:0]    pulses;
    int            cyc;
    logic          dec_sel;
    logic [IW-1:0] iter;
    logic          terr;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb[$];

  // Stub datapath latencies (0 = never answers) and a stray ext pulse cycle.
  int a_lat = 50, b_lat = 52, e_lat = 3;
  int ext_noise_cyc = -1;
  int a_cnt = 0, b_cnt = 0, e_cnt = 0;

  turbo_iter_sched_if #(.MAX_ITER(MAX_ITER)) sif ();

  turbo_iter_sched #(.MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stubs: a launch seen in cycle c answers in cycle c+latency.
  always @(negedge clk) begin
    sif.alpha_out_valid <= (a_cnt == 1);
    sif.beta_out_valid  <= (b_cnt == 1);
    sif.ext_out_valid   <= (e_cnt == 1) || (cyc == ext_noise_cyc);
    a_cnt <= sif.alpha_in_valid ? a_lat : ((a_cnt != 0) ? a_cnt - 1 : 0);
    b_cnt <= sif.beta_in_valid  ? b_lat : ((b_cnt != 0) ? b_cnt - 1 : 0);
    e_cnt <= sif.ext_in_valid   ? e_lat : ((e_cnt != 0) ? e_cnt - 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] p, input int c, input logic d,
                      input logic [IW-1:0] it, input logic te);
    ev_t e;
    e.pulses = p; e.cyc = c; e.dec_sel = d; e.iter = it; e.terr = te;
    sb.push_back(e);
  endtask

  // Frame model. abort_half: abort lands on that half's ext completion.
  // cut_half: only that half's launch is predicted (frame is reset afterwards).
  // fin returns the abort cycle, or the last predicted launch cycle when cut.
  task automatic model_frame(input int launch, input bit es, input int abort_half,
                             input int cut_half, output int fin);
    int            l, m, e;
    logic [IW-1:0] it;
    bit            stop;
    l = launch; it = '0; stop = 1'b0; fin = 0;
    m = (a_lat > b_lat) ? a_lat : b_lat;
    for (int h = 0; h < 2 * MAX_ITER && !stop; h++) begin
      push(EV_AB, l, h[0], it, 1'b0);
      if (h == cut_half) begin
        fin = l; stop = 1'b1;
      end else if (a_lat == 0 || b_lat == 0) begin
        push(EV_DONE, l + TIMEOUT + 1, h[0], it, 1'b1);
        stop = 1'b1;
      end else begin
        push(EV_EXT, l + m + 1, h[0], it, 1'b0);
        e = l + m + 1 + e_lat;
        if (h == abort_half) begin
          push(EV_DONE, e + 1, h[0], it, 1'b0);
          fin = e; stop = 1'b1;
        end else if (h[0]) begin
          it = it + IW'(1);
          if (es || it == IW'(MAX_ITER)) begin
            push(EV_DONE, e + 1, 1'b1, it, 1'b0);
            stop = 1'b1;
          end
        end
        l = e + 1;
      end
    end
  endtask

  // Drives start for one cycle and predicts the frame; returns in the launch cycle.
  task automatic start_frame(input bit es, input int abort_half, input int cut_half,
                             output int launch, output int fin);
    @(negedge clk);
    sif.start      = 1'b1;
    sif.early_stop = es;
    launch         = cyc + 1;
    model_frame(launch, es, abort_half, cut_half, fin);
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || sif.busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending_events"}, sb.size(), 0);
    check({tag, "_busy_after"}, sif.busy, 1'b0);
  endtask

  task automatic monitor();
    logic [3:0] obs;
    ev_t        e;
    forever begin
      @(negedge clk);
      obs = {sif.alpha_in_valid, sif.beta_in_valid, sif.ext_in_valid, sif.frame_done};
      if (obs != 4'b0000) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", obs, 4'b0000);
        end else begin
          e = sb.pop_front();
          check("ev_pulses", obs, e.pulses);
          check("ev_cycle", cyc, e.cyc);
          check("ev_dec_sel", sif.dec_sel, e.dec_sel);
          check("ev_busy", sif.busy, 1'b1);
          if (e.pulses == EV_DONE) begin
            check("done_iter", sif.iter, e.iter);
            check("done_timeout_err", sif.timeout_err, e.terr);
          end
        end
      end
    end
  endtask

  initial begin
    int launch, fin;
    reset          = 1'b1;
    sif.start      = 1'b0;
    sif.abort      = 1'b0;
    sif.early_stop = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", sif.busy, 1'b0);
    check("rst_dec_sel", sif.dec_sel, 1'b0);
    check("rst_iter", sif.iter, 0);
    check("rst_timeout_err", sif.timeout_err, 1'b0);
    check("rst_pulses", {sif.alpha_in_valid, sif.beta_in_valid, sif.ext_in_valid,
                         sif.frame_done}, 4'b0000);

    // Normal frame: two full iterations, dec_sel 0,1,0,1.
    start_frame(1'b0, -1, -1, launch, fin);
    check("busy_at_launch", sif.busy, 1'b1);
    wait_drain("normal");
    check("normal_iter", sif.iter, 2);
    check("normal_dec_sel", sif.dec_sel, 1'b1);

    // Same frame with a start while busy and a stray ext completion in WAIT_AB.
    ext_noise_cyc = cyc + 12;
    start_frame(1'b0, -1, -1, launch, fin);
    wait_until(launch + 20);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    wait_drain("noise");
    check("noise_iter", sif.iter, 2);
    ext_noise_cyc = -1;

    // Completion ordering: beta 10 cycles ahead of alpha, then simultaneous.
    a_lat = 20; b_lat = 10;
    start_frame(1'b0, -1, -1, launch, fin);
    wait_drain("beta_first");
    a_lat = 15; b_lat = 15;
    start_frame(1'b0, -1, -1, launch, fin);
    wait_drain("same_cycle");

    // Early stop on the first decoder-2 extrinsic completion.
    a_lat = 50; b_lat = 52;
    start_frame(1'b1, -1, -1, launch, fin);
    wait_drain("early_stop");
    check("es_iter", sif.iter, 1);
    check("es_dec_sel", sif.dec_sel, 1'b1);
    sif.early_stop = 1'b0;

    // Watchdog: beta never answers.
    b_lat = 0;
    start_frame(1'b0, -1, -1, launch, fin);
    wait_drain("timeout");
    check("timeout_err_sticky", sif.timeout_err, 1'b1);
    b_lat = 52;

    // Abort coinciding with the decoder-2 ext completion; also clears timeout_err.
    start_frame(1'b0, 1, -1, launch, fin);
    check("start_clears_timeout_err", sif.timeout_err, 1'b0);
    wait_until(fin);
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    wait_drain("abort");
    check("abort_iter", sif.iter, 0);

    // Reset during WAIT_AB of the decoder-2 half; stray completions follow.
    start_frame(1'b0, -1, 1, launch, fin);
    wait_until(fin + 5);
    check("pre_reset_dec_sel", sif.dec_sel, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", sif.busy, 1'b0);
    check("mid_rst_dec_sel", sif.dec_sel, 1'b0);
    check("mid_rst_pulses", {sif.alpha_in_valid, sif.beta_in_valid, sif.ext_in_valid,
                             sif.frame_done}, 4'b0000);
    repeat (80) @(negedge clk);
    check("post_rst_pending", sb.size(), 0);
    check("post_rst_busy", sif.busy, 1'b0);
    check("post_rst_iter", sif.iter, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
